// File: rtl/coo_beat_issuer.sv
// coo_beat_issuer: reads packed COO nonzeros from a synchronous entry memory
// and packs them into NUM_CHANNELS-lane beats for the SpMV row accumulator.
// Each beat is presented with a one-cycle rdy pulse, and pulses are spaced at
// least ISSUE_GAP cycles apart. Lanes with no entry carry the sentinel
// (value=0, col_id=0, row_id=MATRIX_SIZE). The stream always ends with an
// all-sentinel beat.
//
// Handshake: rdy is a one-cycle valid strobe with no backpressure. The
// consumer must take values/col_id/row_id in the cycle rdy is high. The lane
// outputs are don't-care while rdy is low.
//
// dbg_state encoding: 0 IDLE, 1 REQ, 2 WAIT, 3 ISSUE, 4 GAP, 5 FLUSH, 6 DONE.
module coo_beat_issuer #(
  parameter int NUM_CHANNELS = 4,
  parameter int MATRIX_SIZE  = 128,
  parameter int ADDR_W       = 16,
  parameter int ISSUE_GAP    = 2
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         start,
  input  logic [31:0]                  nnz,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_rd,
  input  logic [95:0]                  mem_rdata,
  output logic [NUM_CHANNELS*32-1:0]   values,
  output logic [NUM_CHANNELS*32-1:0]   col_id,
  output logic [NUM_CHANNELS*32-1:0]   row_id,
  output logic                         rdy,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [2:0]                   dbg_state
);

  localparam int LC_W    = $clog2(NUM_CHANNELS + 1);
  // GAP cycles after each rdy: ISSUE_GAP-1, but never fewer than one, so two
  // rdy pulses are never adjacent.
  localparam int GAP_CYC = (ISSUE_GAP > 2) ? (ISSUE_GAP - 1) : 1;
  localparam int GC_W    = $clog2(GAP_CYC + 1);
  localparam logic [31:0] SENT_ROW = 32'(MATRIX_SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_GAP   = 3'd4,
    S_FLUSH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [31:0]       r_rd_ptr;
  logic [31:0]       r_nnz_q;
  logic [LC_W-1:0]   r_lane_cnt;
  logic              r_pend_v;
  logic [95:0]       r_pend_d;
  logic [GC_W-1:0]   r_gap_cnt;
  logic              r_err;
  logic [31:0]       r_val [NUM_CHANNELS];
  logic [31:0]       r_col [NUM_CHANNELS];
  logic [31:0]       r_row [NUM_CHANNELS];

  logic              w_start_ok;
  logic [31:0]       w_rd_row;
  logic              w_row_bad;
  logic              w_conflict;
  logic [31:0]       w_ptr_next;
  logic              w_last_next;
  logic              w_lanes_full_next;
  logic              w_gap_first;
  logic              w_gap_leave;

  assign w_start_ok        = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_rd_row          = mem_rdata[31:0];
  assign w_row_bad         = (w_rd_row >= SENT_ROW);
  assign w_ptr_next        = r_rd_ptr + 32'd1;
  assign w_last_next       = (w_ptr_next == r_nnz_q);
  assign w_lanes_full_next = (r_lane_cnt == LC_W'(NUM_CHANNELS - 1));
  assign w_gap_first       = (r_gap_cnt == '0);
  assign w_gap_leave       = (r_gap_cnt == GC_W'(GAP_CYC - 1));

  // Same-row conflict: the incoming row already sits in one of the filled lanes.
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if ((LC_W'(i) < r_lane_cnt) && (r_row[i] == w_rd_row)) begin
        w_conflict = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          w_next = (nnz == 32'd0) ? S_FLUSH : S_REQ;
        end
      end
      S_REQ: w_next = S_WAIT;
      S_WAIT: begin
        if (w_row_bad) begin
          if (w_last_next) begin
            w_next = (r_lane_cnt != '0) ? S_ISSUE : S_FLUSH;
          end else begin
            w_next = S_REQ;
          end
        end else if (w_conflict) begin
          w_next = S_ISSUE;
        end else if (w_lanes_full_next || w_last_next) begin
          w_next = S_ISSUE;
        end else begin
          w_next = S_REQ;
        end
      end
      S_ISSUE: w_next = S_GAP;
      S_GAP: begin
        if (w_gap_leave) begin
          if (r_pend_v) begin
            w_next = (w_last_next || (NUM_CHANNELS == 1)) ? S_ISSUE : S_REQ;
          end else if (r_rd_ptr == r_nnz_q) begin
            w_next = S_FLUSH;
          end else begin
            w_next = S_REQ;
          end
        end
      end
      S_FLUSH: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: read pointer, lane fill, pending buffer, gap timer and error flag.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_rd_ptr   <= '0;
      r_nnz_q    <= '0;
      r_lane_cnt <= '0;
      r_pend_v   <= 1'b0;
      r_pend_d   <= '0;
      r_gap_cnt  <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_val[i] <= '0;
        r_col[i] <= '0;
        r_row[i] <= SENT_ROW;
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_nnz_q    <= nnz;
            r_rd_ptr   <= '0;
            r_lane_cnt <= '0;
            r_pend_v   <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              r_val[i] <= '0;
              r_col[i] <= '0;
              r_row[i] <= SENT_ROW;
            end
          end
        end
        S_WAIT: begin
          if (w_row_bad) begin
            // Out-of-range row: flag it and skip the entry.
            r_err    <= 1'b1;
            r_rd_ptr <= w_ptr_next;
          end else if (w_conflict) begin
            // Hold the entry for the next beat; it is consumed when leaving GAP.
            r_pend_v <= 1'b1;
            r_pend_d <= mem_rdata;
          end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              if (r_lane_cnt == LC_W'(i)) begin
                r_val[i] <= mem_rdata[95:64];
                r_col[i] <= mem_rdata[63:32];
                r_row[i] <= mem_rdata[31:0];
              end
            end
            r_lane_cnt <= r_lane_cnt + LC_W'(1);
            r_rd_ptr   <= w_ptr_next;
          end
        end
        S_ISSUE: begin
          r_gap_cnt <= '0;
        end
        S_GAP: begin
          if (w_gap_first) begin
            r_lane_cnt <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              r_val[i] <= '0;
              r_col[i] <= '0;
              r_row[i] <= SENT_ROW;
            end
          end
          if (!w_gap_leave) begin
            r_gap_cnt <= r_gap_cnt + GC_W'(1);
          end else if (r_pend_v) begin
            // Later assignments override the sentinel fill above.
            r_val[0]   <= r_pend_d[95:64];
            r_col[0]   <= r_pend_d[63:32];
            r_row[0]   <= r_pend_d[31:0];
            r_lane_cnt <= LC_W'(1);
            r_rd_ptr   <= w_ptr_next;
            r_pend_v   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Flatten the lane registers onto the beat buses.
  always_comb begin
    values = '0;
    col_id = '0;
    row_id = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      values[i*32 +: 32] = r_val[i];
      col_id[i*32 +: 32] = r_col[i];
      row_id[i*32 +: 32] = r_row[i];
    end
  end

  assign mem_addr  = r_rd_ptr[ADDR_W-1:0];
  assign mem_rd    = (r_state == S_REQ);
  assign rdy       = (r_state == S_ISSUE) || (r_state == S_FLUSH);
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: doc/coo_beat_issuer.md
Name: coo_beat_issuer

Overview:
- Producer end of the COO beat interface consumed by the SpMV row accumulator.
- Reads packed nonzeros (value, col_id, row_id) from a synchronous entry memory and packs them into NUM_CHANNELS-lane beats.
- Presents each beat with a one-cycle rdy pulse, spaced to the accumulator's accept rate.
- Pads unused lanes and terminates the stream with an all-sentinel beat, which drives the accumulator to DONE.

Parameters:
NUM_CHANNELS, 4, lanes per beat
MATRIX_SIZE, 128, row count; a row_id of MATRIX_SIZE is the sentinel meaning "lane finished"
ADDR_W, 16, entry-memory address width
ISSUE_GAP, 2, minimum cycles from one rdy pulse to the next (rdy-to-rdy spacing)

Ports:
clk  in  1  clock
rst_l  in  1  reset; asynchronous, active-low
start  in  1  one-cycle pulse; accepted only in IDLE or DONE
nnz  in  32  nonzero count, sampled on start
mem_addr  out  ADDR_W  entry address
mem_rd  out  1  read strobe; data returns on the next cycle
mem_rdata  in  96  packed entry: [95:64] value, [63:32] col_id, [31:0] row_id
values  out  NUM_CHANNELS*32  lane matrix values
col_id  out  NUM_CHANNELS*32  lane column indices
row_id  out  NUM_CHANNELS*32  lane row indices
rdy  out  1  beat valid; one-cycle pulse
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
err  out  1  sticky; set when an entry with row_id >= MATRIX_SIZE is read

Behaviour:
- Reset values:
  - state=IDLE; rdy, mem_rd, busy, done, err = 0; mem_addr = 0.
  - Every lane holds value=0, col_id=0, row_id=MATRIX_SIZE.
- Registers: rd_ptr (32b), nnz_q, lane_cnt (0..NUM_CHANNELS), 1-entry pending buffer with valid flag, gap counter.
- IDLE/DONE, on start:
  - latch nnz; clear rd_ptr, lane_cnt, pending, err.
  - nnz=0 -> FLUSH; otherwise -> REQ.
- REQ: mem_rd=1, mem_addr=rd_ptr[ADDR_W-1:0] -> WAIT. Only one read is outstanding at a time.
- WAIT: mem_rdata is valid this cycle; entry row r is handled by the first matching rule:
  - r >= MATRIX_SIZE: set err, drop the entry, rd_ptr++. Then -> ISSUE if rd_ptr==nnz_q and lane_cnt>0; -> FLUSH if rd_ptr==nnz_q and lane_cnt==0; else -> REQ.
  - r equals row_id of any already-filled lane (same-row conflict, because the accumulator's per-row update is last-write-wins): store the entry in pending, leave rd_ptr unchanged, -> ISSUE.
  - Otherwise: write the entry into lane[lane_cnt], lane_cnt++, rd_ptr++. Then -> ISSUE if lane_cnt==NUM_CHANNELS or rd_ptr==nnz_q; else -> REQ.
- ISSUE: rdy=1 for exactly one cycle; lane outputs are stable this cycle and unfilled lanes carry the sentinel. -> GAP.
- GAP:
  - In the first GAP cycle, reset all lanes to sentinel and set lane_cnt=0. Lane outputs are don't-care while rdy=0.
  - Stay in GAP until ISSUE_GAP-1 cycles have elapsed since rdy, with a minimum of 1 GAP cycle, so no two rdy pulses are ever adjacent.
  - On leaving GAP:
    - Pending valid: move it into lane0, lane_cnt=1, rd_ptr++, clear pending. Then -> ISSUE if rd_ptr==nnz_q or NUM_CHANNELS==1; else -> REQ.
    - Else if rd_ptr==nnz_q: -> FLUSH.
    - Else: -> REQ.
- FLUSH:
  - Requires at least ISSUE_GAP cycles since the previous rdy; the GAP path already guarantees this.
  - rdy=1 with all lanes sentinel -> DONE.
- DONE: done=1, busy=0; hold until start.
- start while busy is ignored.
- Reset mid-operation returns everything to reset values; no partial beat is emitted.
- rd_ptr compares use the full 32 bits; mem_addr wraps modulo 2^ADDR_W.

Test Plan:
- nnz=0, start -> exactly one rdy with all row_id=128, then done=1; mem_rd never asserted.
- nnz=8, entries with rows 0..7, col=row, value=row+1 -> beats {rows 0,1,2,3}, {rows 4,5,6,7}, then a sentinel beat; exactly 3 rdy pulses, each pair separated by >=1 idle cycle; done follows.
- nnz=5, rows 0,0,1,2,3 -> beats {0,S,S,S}, {0,1,2,3}, then the sentinel beat (S=128); no lane row duplicated within a beat.
- nnz=6, rows 10..15 -> beats {10,11,12,13}, {14,15,S,S}, then the sentinel beat.
- nnz=3, middle entry row=200 -> err=1; beats {r0,r2,S,S}, then the sentinel beat; done asserted.
- Assert rst_l low during the second beat's WAIT, then start with nnz=4 -> clean restart; first rdy carries entries 0..3 from address 0.
